// File: rtl/mixcolumns_seq.sv
// AES MixColumns over a 128-bit state, COLS_PER_CYCLE columns per clock.
// Latency: 4/COLS_PER_CYCLE RUN cycles after accept; bypass goes straight to DONE.
// Backpressure: single job in flight; in_ready only in IDLE, DONE holds until out_ready.
module mixcolumns_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_bypass,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  input  logic         abort,
  output logic         busy
);

  localparam int NGRP = 4 / COLS_PER_CYCLE;
  localparam int GW   = (NGRP > 1) ? $clog2(NGRP) : 1;
  localparam logic [GW-1:0] LAST_GRP = GW'(NGRP - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    r_state;
  logic [GW-1:0] r_grp;
  logic [127:0]  r_src;
  logic [127:0]  r_res;
  logic          r_live;

  logic [1:0]  w_idx     [COLS_PER_CYCLE];
  logic [31:0] w_col_in  [COLS_PER_CYCLE];
  logic [31:0] w_col_out [COLS_PER_CYCLE];
  logic        w_accept;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte 0 of the column word is row 0.
  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] r0, r1, r2, r3;
    a0 = col[7:0];
    a1 = col[15:8];
    a2 = col[23:16];
    a3 = col[31:24];
    r0 = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
    r1 = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
    r2 = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
    r3 = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
    return {r3, r2, r1, r0};
  endfunction

  // Only COLS_PER_CYCLE mixers exist; the group counter steers src columns into them.
  for (genvar j = 0; j < COLS_PER_CYCLE; j++) begin : g_mix
    assign w_idx[j]     = 2'(int'(r_grp) * COLS_PER_CYCLE + j);
    assign w_col_in[j]  = r_src[{w_idx[j], 5'd0} +: 32];
    assign w_col_out[j] = mix_col(w_col_in[j]);
  end

  // r_live keeps in_ready low during reset and until the first edge after release.
  assign in_ready  = r_live && (r_state == S_IDLE);
  assign w_accept  = in_valid && in_ready;
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state == S_RUN) || (r_state == S_DONE);
  assign out_data  = r_res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_grp   <= '0;
      r_src   <= '0;
      r_res   <= '0;
      r_live  <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (abort) begin
        r_state <= S_IDLE;
        r_grp   <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_accept) begin
              r_src <= in_data;
              r_grp <= '0;
              if (in_bypass) begin
                r_res   <= in_data;
                r_state <= S_DONE;
              end else begin
                r_state <= S_RUN;
              end
            end
          end
          S_RUN: begin
            for (int j = 0; j < COLS_PER_CYCLE; j++) begin
              r_res[{w_idx[j], 5'd0} +: 32] <= w_col_out[j];
            end
            if (r_grp == LAST_GRP) begin
              r_grp   <= '0;
              r_state <= S_DONE;
            end else begin
              r_grp <= r_grp + 1'b1;
            end
          end
          S_DONE: begin
            if (out_ready) r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mixcolumns_seq.sv
// Bench for mixcolumns_seq: three instances (1, 2 and 4 columns per cycle) checked
// against known-answer vectors and a GF(2^8) matrix reference model.
module tb_mixcolumns_seq;

  logic         clk;
  logic         rst_n;
  logic [2:0]   in_valid, in_ready, in_bypass, out_valid, out_ready, abort_s, busy;
  logic [127:0] in_data  [3];
  logic [127:0] out_data [3];

  int n_chk  = 0;
  int n_pass = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int C = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
    mixcolumns_seq #(.COLS_PER_CYCLE(C)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_data   (in_data[g]),
      .in_bypass (in_bypass[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_data  (out_data[g]),
      .abort     (abort_s[g]),
      .busy      (busy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [127:0] din;
    logic         byp;
    logic [127:0] dout;
  } vec_t;

  vec_t vecs [3];

  function automatic int cols(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 2 : 4);
  endfunction

  // Words are written row0..row3, most significant byte first.
  function automatic logic [127:0] pack4(input logic [31:0] w0, w1, w2, w3);
    logic [31:0]  ws [4];
    logic [127:0] v;
    ws[0] = w0; ws[1] = w1; ws[2] = w2; ws[3] = w3;
    v = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        v[8*(4*c+r) +: 8] = ws[c][31-8*r -: 8];
    return v;
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--)
      if (p[i]) p = p ^ (15'(9'h11b) << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] coef(input int d);
    case (d)
      0:       return 8'd2;
      1:       return 8'd3;
      default: return 8'd1;
    endcase
  endfunction

  function automatic logic [127:0] ref_mix(input logic [127:0] din, input logic byp);
    logic [127:0] v;
    logic [7:0]   acc;
    if (byp) return din;
    v = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = '0;
        for (int i = 0; i < 4; i++)
          acc = acc ^ gf_mul(din[8*(4*c+i) +: 8], coef((i - r + 4) % 4));
        v[8*(4*c+r) +: 8] = acc;
      end
    return v;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input int k, input logic [127:0] din, input logic byp,
                         input logic [127:0] exp, input string tag);
    int n;
    int lat;
    n = 0;
    while (!in_ready[k] && n < 20) begin tick(); n++; end
    chk({tag, " in_ready"}, 128'(in_ready[k]), 128'd1);
    in_valid[k]  = 1'b1;
    in_data[k]   = din;
    in_bypass[k] = byp;
    tick();
    in_valid[k]  = 1'b0;
    in_data[k]   = rnd128();
    in_bypass[k] = ~byp;
    lat = 0;
    while (!out_valid[k] && lat < 20) begin tick(); lat++; end
    chk({tag, " latency"}, 128'(lat), 128'(byp ? 0 : 4 / cols(k)));
    chk({tag, " data"}, out_data[k], exp);
    out_ready[k] = 1'b1;
    tick();
    out_ready[k] = 1'b0;
    chk({tag, " in_ready after"}, 128'(in_ready[k]), 128'd1);
    chk({tag, " out_valid after"}, 128'(out_valid[k]), 128'd0);
  endtask

  initial begin
    logic [127:0] d, hold;
    int n, seen;

    vecs[0] = '{"kat1",
                pack4(32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hc6c6c6c6), 1'b0,
                pack4(32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6)};
    vecs[1] = '{"kat2",
                pack4(32'hd4d4d4d5, 32'h2d26314c, 32'h00000000, 32'hffffffff), 1'b0,
                pack4(32'hd5d5d7d6, 32'h4d7ebdf8, 32'h00000000, 32'hffffffff)};
    vecs[2] = '{"bypass",
                128'h0123456789abcdef_fedcba9876543210, 1'b1,
                128'h0123456789abcdef_fedcba9876543210};

    rst_n     = 1'b0;
    in_valid  = '0;
    in_bypass = '0;
    out_ready = '0;
    abort_s   = '0;
    for (int k = 0; k < 3; k++) in_data[k] = '0;

    #22;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst in_ready[%0d]", k), 128'(in_ready[k]), 128'd0);
      chk($sformatf("rst out_valid[%0d]", k), 128'(out_valid[k]), 128'd0);
      chk($sformatf("rst busy[%0d]", k), 128'(busy[k]), 128'd0);
      chk($sformatf("rst out_data[%0d]", k), out_data[k], 128'd0);
    end
    rst_n = 1'b1;
    #1;
    chk("in_ready before first edge", 128'(in_ready[0]), 128'd0);
    tick();
    chk("in_ready after first edge", 128'(in_ready), 128'h7);

    for (int k = 0; k < 3; k++)
      for (int v = 0; v < 3; v++)
        run_job(k, vecs[v].din, vecs[v].byp, vecs[v].dout,
                $sformatf("%s c%0d", vecs[v].name, cols(k)));

    // Backpressure in DONE with stray in_valid pulses.
    d = rnd128();
    in_valid[0] = 1'b1; in_data[0] = d; in_bypass[0] = 1'b0;
    tick();
    in_valid[0] = 1'b0;
    n = 0;
    while (!out_valid[0] && n < 20) begin tick(); n++; end
    hold = out_data[0];
    chk("bp data", hold, ref_mix(d, 1'b0));
    for (int i = 0; i < 10; i++) begin
      in_valid[0] = i[0];
      in_data[0]  = rnd128();
      tick();
      chk("bp out_valid", 128'(out_valid[0]), 128'd1);
      chk("bp out_data stable", out_data[0], hold);
      chk("bp in_ready", 128'(in_ready[0]), 128'd0);
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    tick();
    out_ready[0] = 1'b0;
    chk("bp release out_valid", 128'(out_valid[0]), 128'd0);
    chk("bp release busy", 128'(busy[0]), 128'd0);
    chk("bp release in_ready", 128'(in_ready[0]), 128'd1);

    // Abort during the second RUN cycle.
    in_valid[0] = 1'b1; in_data[0] = rnd128(); in_bypass[0] = 1'b0;
    tick();
    in_valid[0] = 1'b0;
    tick();
    abort_s[0] = 1'b1;
    tick();
    abort_s[0] = 1'b0;
    chk("abort out_valid", 128'(out_valid[0]), 128'd0);
    chk("abort busy", 128'(busy[0]), 128'd0);
    chk("abort in_ready", 128'(in_ready[0]), 128'd1);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid[0]) seen++;
    end
    chk("abort no output", 128'(seen), 128'd0);
    d = rnd128();
    run_job(0, d, 1'b0, ref_mix(d, 1'b0), "post-abort");

    // Asynchronous reset with jobs in flight (instance 2 is already in DONE).
    for (int k = 0; k < 3; k++) begin
      in_valid[k] = 1'b1; in_data[k] = rnd128(); in_bypass[k] = 1'b0;
    end
    tick();
    in_valid = '0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("arst out_valid[%0d]", k), 128'(out_valid[k]), 128'd0);
      chk($sformatf("arst busy[%0d]", k), 128'(busy[k]), 128'd0);
      chk($sformatf("arst in_ready[%0d]", k), 128'(in_ready[k]), 128'd0);
      chk($sformatf("arst out_data[%0d]", k), out_data[k], 128'd0);
    end
    tick();
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      d = rnd128();
      run_job(k, d, 1'b0, ref_mix(d, 1'b0), $sformatf("post-rst c%0d", cols(k)));
    end

    // Randomized jobs against the matrix model.
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 12; i++) begin
        logic b;
        d = rnd128();
        b = ($urandom_range(0, 3) == 0);
        run_job(k, d, b, ref_mix(d, b), $sformatf("rnd c%0d #%0d", cols(k), i));
      end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
